// File: rtl/alu_pkg.sv
// Shared types for the bit-serial arithmetic path: sequencer states and the default operand width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_slice.sv
// One-bit full adder: the single arithmetic slice reused on every serial step.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (w_s0),
        .c_out (w_c0)
    );

    half_adder u_ha1 (
        .a     (w_s0),
        .b     (c_in),
        .sum   (sum),
        .c_out (w_c1)
    );

    assign c_out = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR make the full-adder slice.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b;
    assign c_out = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice, LSB first, one bit per clock,
// with valid/ready handshakes on both sides and a single operation in flight.
module serial_adder_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_c_out;
    logic               r_msb_cin;
    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    fa_slice u_slice (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c_in  (r_carry),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_next = {w_sum, r_res_sh[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res_sh  <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_c_out   <= 1'b0;
            r_msb_cin <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    // Subtraction folds into addition: A + ~B with carry-in 1.
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result  <= w_res_next;
                        r_c_out   <= w_cout;
                        r_msb_cin <= r_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign c_out     = r_c_out;
    assign ovf       = r_msb_cin ^ r_c_out;

endmodule
